// File: rtl/sap_control_sequencer.sv
// T-state control sequencer for the 8-bit bus CPU: fetch T1-T3, execute T4-T7.
// Ports: clk, clr (async active-low), run/step, opcode, cout -> bus strobes, carry_flag, halted, tstate.
module sap_control_sequencer #(
  parameter int OPW = 4,
  parameter logic [OPW-1:0] OP_LDA = 'h0,
  parameter logic [OPW-1:0] OP_ADD = 'h1,
  parameter logic [OPW-1:0] OP_JMP = 'h3,
  parameter logic [OPW-1:0] OP_JC  = 'h4,
  parameter logic [OPW-1:0] OP_OUT = 'he,
  parameter logic [OPW-1:0] OP_HLT = 'hf
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic           step,
  input  logic [OPW-1:0] opcode,
  input  logic           cout,
  output logic           cp,
  output logic           ep,
  output logic           pl,
  output logic           lm,
  output logic           ce,
  output logic           li,
  output logic           ei,
  output logic           la,
  output logic           lb,
  output logic           ev,
  output logic           ea,
  output logic           lo,
  output logic           carry_flag,
  output logic           halted,
  output logic [2:0]     tstate
);

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5,
    T7 = 3'd6
  } tst_t;

  typedef struct packed {
    logic cp, ep, pl, lm, ce, li, ei;
    logic la, lb, ev, ea, lo;
  } ctrl_t;

  tst_t  st;
  ctrl_t dec;
  logic  adv;
  logic  gate;

  assign adv  = (run | step) & ~halted;
  // Strobes are qualified by adv so each load fires once per T-state,
  // and by clr so nothing drives the bus while reset is held.
  assign gate = adv & clr;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st         <= T1;
      carry_flag <= 1'b0;
      halted     <= 1'b0;
    end else if (adv) begin
      unique case (st)
        T1: st <= T2;
        T2: st <= T3;
        T3: st <= T4;
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD) begin
            st <= T5;
          end else if (opcode == OP_HLT) begin
            halted <= 1'b1;
          end else begin
            st <= T1;
          end
        end
        T5: st <= (opcode == OP_ADD) ? T6 : T1;
        T6: begin
          carry_flag <= cout;
          st         <= T7;
        end
        T7: st <= T1;
        default: st <= T1;
      endcase
    end
  end

  always_comb begin
    dec = '0;
    unique case (st)
      T1: begin
        dec.ep = 1'b1;
        dec.lm = 1'b1;
      end
      T2: dec.cp = 1'b1;
      T3: begin
        dec.ce = 1'b1;
        dec.li = 1'b1;
      end
      T4: begin
        if (opcode == OP_LDA || opcode == OP_ADD) begin
          dec.ei = 1'b1;
          dec.lm = 1'b1;
        end else if (opcode == OP_OUT) begin
          dec.ea = 1'b1;
          dec.lo = 1'b1;
        end else if (opcode == OP_JMP ||
                     (opcode == OP_JC && carry_flag)) begin
          dec.ei = 1'b1;
          dec.pl = 1'b1;
        end
      end
      T5: begin
        dec.ce = 1'b1;
        if (opcode == OP_ADD) dec.lb = 1'b1;
        else                  dec.la = 1'b1;
      end
      T6: dec.ev = 1'b1;
      T7: begin
        dec.ea = 1'b1;
        dec.la = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  assign cp = dec.cp & gate;
  assign ep = dec.ep & gate;
  assign pl = dec.pl & gate;
  assign lm = dec.lm & gate;
  assign ce = dec.ce & gate;
  assign li = dec.li & gate;
  assign ei = dec.ei & gate;
  assign la = dec.la & gate;
  assign lb = dec.lb & gate;
  assign ev = dec.ev & gate;
  assign ea = dec.ea & gate;
  assign lo = dec.lo & gate;

  assign tstate = st;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: scripted instruction flows checked
// against expected strobe sets queued per cycle.
module tb_sap_control_sequencer;

  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] PL = 12'h200;
  localparam logic [11:0] LM = 12'h100;
  localparam logic [11:0] CE = 12'h080;
  localparam logic [11:0] LI = 12'h040;
  localparam logic [11:0] EI = 12'h020;
  localparam logic [11:0] LA = 12'h010;
  localparam logic [11:0] LB = 12'h008;
  localparam logic [11:0] EV = 12'h004;
  localparam logic [11:0] EA = 12'h002;
  localparam logic [11:0] LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] JMP = 4'b0011;
  localparam logic [3:0] JC  = 4'b0100;
  localparam logic [3:0] UND = 4'b0101;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic       step;
  logic [3:0] opcode;
  logic       cout;
  logic       cp, ep, pl, lm, ce, li, ei;
  logic       la, lb, ev, ea, lo;
  logic       carry_flag, halted;
  logic [2:0] tstate;
  logic [11:0] sv;

  int tests = 0;
  int fails = 0;
  logic [11:0] sbq[$];

  assign sv = {cp, ep, pl, lm, ce, li, ei, la, lb, ev, ea, lo};

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .step(step),
    .opcode(opcode), .cout(cout),
    .cp(cp), .ep(ep), .pl(pl), .lm(lm), .ce(ce),
    .li(li), .ei(ei), .la(la), .lb(lb), .ev(ev),
    .ea(ea), .lo(lo), .carry_flag(carry_flag),
    .halted(halted), .tstate(tstate)
  );

  // Bus rule: never more than one driver on W.
  always @(negedge clk) begin
    if (!$onehot0({ep, ce, ei, ea})) begin
      fails++;
      $display("FAIL bus_contention ep=%b ce=%b ei=%b ea=%b t=%0t",
               ep, ce, ei, ea, $time);
    end
  end

  function automatic logic add_cout(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  // One clock: drive, queue expectation, sample mid-cycle, compare.
  task automatic cyc(input logic r, input logic s,
                     input logic [11:0] exp);
    logic [11:0] e;
    run  = r;
    step = s;
    sbq.push_back(exp);
    @(negedge clk);
    e = sbq.pop_front();
    tests++;
    if (sv !== e) begin
      fails++;
      $display("FAIL strobes got=%h exp=%h t=%0t", sv, e, $time);
    end
    @(posedge clk);
    #1;
    run  = 1'b0;
    step = 1'b0;
  endtask

  task automatic chk_t(input string nm, input logic [2:0] exp);
    tests++;
    if (tstate !== exp) begin
      fails++;
      $display("FAIL %s tstate got=%0d exp=%0d", nm, tstate, exp);
    end
  endtask

  task automatic chk_c(input string nm, input logic exp);
    tests++;
    if (carry_flag !== exp) begin
      fails++;
      $display("FAIL %s carry got=%b exp=%b", nm, carry_flag, exp);
    end
  endtask

  task automatic fetch(input logic r);
    cyc(r, ~r, EP | LM);
    cyc(r, ~r, CP);
    cyc(r, ~r, CE | LI);
  endtask

  task automatic test_reset;
    run = 1'b1;
    #1;
    tests++;
    if (sv !== NONE || tstate !== 3'd0 ||
        carry_flag !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset sv=%h t=%0d c=%b h=%b",
               sv, tstate, carry_flag, halted);
    end
    @(posedge clk);
    #1;
    clr = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_lda;
    opcode = LDA;
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LA);
    chk_t("lda_end", 3'd0);
    chk_c("lda_keep", 1'b0);
  endtask

  task automatic test_add_carry_jc;
    opcode = ADD;
    cout = add_cout(8'hf0, 8'h20);
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LB);
    cyc(1'b1, 1'b0, EV);
    chk_c("add_carry_set", 1'b1);
    cyc(1'b1, 1'b0, EA | LA);
    chk_t("add_end", 3'd0);
    opcode = JC;
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | PL);
    chk_t("jc_taken_end", 3'd0);
  endtask

  task automatic test_out_jmp_und;
    opcode = OUT;
    fetch(1'b1);
    cyc(1'b1, 1'b0, EA | LO);
    chk_c("out_keep", 1'b1);
    opcode = JMP;
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | PL);
    chk_c("jmp_keep", 1'b1);
    opcode = UND;
    fetch(1'b1);
    cyc(1'b1, 1'b0, NONE);
    chk_t("und_end", 3'd0);
  endtask

  task automatic test_reset_mid;
    opcode = ADD;
    cout = add_cout(8'hf0, 8'h20);
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LB);
    run = 1'b1;
    tests++;
    if (sv !== EV) begin
      fails++;
      $display("FAIL mid_t6 got=%h exp=%h", sv, EV);
    end
    #1;
    clr = 1'b0;
    #1;
    tests++;
    if (sv !== NONE || tstate !== 3'd0 || carry_flag !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset sv=%h t=%0d c=%b",
               sv, tstate, carry_flag);
    end
    @(posedge clk);
    #1;
    clr = 1'b1;
    cyc(1'b1, 1'b0, EP | LM);
    chk_t("after_mid_reset", 3'd1);
    cyc(1'b1, 1'b0, CP);
    cyc(1'b1, 1'b0, CE | LI);
    opcode = LDA;
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LA);
  endtask

  task automatic test_add_nocarry_jc;
    opcode = ADD;
    cout = add_cout(8'h01, 8'h02);
    fetch(1'b1);
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LB);
    cyc(1'b1, 1'b0, EV);
    cyc(1'b1, 1'b0, EA | LA);
    chk_c("add_nocarry", 1'b0);
    opcode = JC;
    fetch(1'b1);
    cyc(1'b1, 1'b0, NONE);
    chk_t("jc_not_taken_end", 3'd0);
  endtask

  task automatic test_step;
    logic [11:0] seq[6];
    seq = '{EP | LM, CP, CE | LI, EI | LM, CE | LA, EP | LM};
    opcode = LDA;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, seq[i]);
      for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0, NONE);
    end
    chk_t("step_pos", 3'd1);
    cyc(1'b1, 1'b1, CP);
    chk_t("run_and_step", 3'd2);
    cyc(1'b1, 1'b0, CE | LI);
    cyc(1'b1, 1'b0, EI | LM);
    cyc(1'b1, 1'b0, CE | LA);
    chk_t("step_end", 3'd0);
  endtask

  task automatic test_hlt;
    opcode = HLT;
    fetch(1'b1);
    cyc(1'b1, 1'b0, NONE);
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL hlt_set halted got=%b exp=1", halted);
    end
    chk_t("hlt_t4", 3'd3);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, NONE);
    chk_t("hlt_held", 3'd3);
    clr = 1'b0;
    #2;
    clr = 1'b1;
    tests++;
    if (halted !== 1'b0 || tstate !== 3'd0) begin
      fails++;
      $display("FAIL hlt_clear halted=%b t=%0d exp 0/0",
               halted, tstate);
    end
    opcode = LDA;
    cyc(1'b1, 1'b0, EP | LM);
    chk_t("hlt_resume", 3'd1);
  endtask

  initial begin
    clr = 1'b0;
    run = 1'b0;
    step = 1'b0;
    opcode = LDA;
    cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lda();
    test_add_carry_jc();
    test_out_jmp_und();
    test_reset_mid();
    test_add_nocarry_jc();
    test_step();
    test_hlt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
